// File: rtl/gpio_pkg.sv
// ----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO pin arbiter and anything else that needs a
// round-robin pick (e.g. the bus interconnect).
//   gpio_arb_state_e : arbiter FSM states
//   rr_pick()        : round-robin search returning {found, index}
// ----------------------------------------------------------------------------
package gpio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        HANDOVER = 2'd2
    } gpio_arb_state_e;

    // rr_pick works on a fixed maximum width; callers zero-extend their
    // request vector and pass the real requester count.
    localparam int unsigned RrMaxReq = 32;
    localparam int unsigned RrIdxW   = 5;

    typedef struct packed {
        logic              found;
        logic [RrIdxW-1:0] index;
    } rr_pick_t;

    // First set bit of req[num_req-1:0], searching upward from ptr with
    // wrap-around. ptr must be below num_req.
    function automatic rr_pick_t rr_pick(input logic [RrMaxReq-1:0] req,
                                         input int unsigned         num_req,
                                         input int unsigned         ptr);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 0; i < RrMaxReq; i++) begin
            if (i < num_req) begin
                idx = ptr + i;
                // ptr and i are both below num_req, so one subtract wraps.
                if (idx >= num_req) idx = idx - num_req;
                if (!res.found && req[idx[RrIdxW-1:0]]) begin
                    res.found = 1'b1;
                    res.index = idx[RrIdxW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker (NumReq <= 32).
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   valid : at least one request present
//   idx   : winning index (first set bit from ptr upward, wrapping)
// ----------------------------------------------------------------------------
module rr_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdW-1:0]    ptr,
    output logic              valid,
    output logic [IdW-1:0]    idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(RrMaxReq'(req), NumReq, int'(ptr));
        valid = pick.found;
        idx   = IdW'(pick.index);
    end

endmodule

// File: rtl/gpio_pin_arbiter.sv
// ----------------------------------------------------------------------------
// gpio_pin_arbiter
// Shares one GPIO pin bank between the register bank and NumReq hardware
// requesters. One requester owns the bank at a time (round-robin grant), every
// hand-back passes through one all-tristate turnaround cycle, and ownership is
// bounded by TimeoutCycles (0 = unbounded).
//   clk, rst          : clock, synchronous active-high reset
//   req / rel         : per-requester request level / one-cycle release
//   grant             : registered one-hot ownership
//   req_dir / req_out : packed requester vectors, requester r at [r*NumIO +: NumIO]
//   reg_dir / reg_out : register-bank vectors, used when nobody owns the bank
//   pin_dir / pin_out : to the pin drivers
//   busy              : state != IDLE
//   owner_id          : current or last owner
//   timeout_evt       : one-cycle pulse when the timeout alone forced a release
// ----------------------------------------------------------------------------
module gpio_pin_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned NumIO         = 32,
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumReq-1:0]       req,
    input  logic [NumReq-1:0]       rel,
    output logic [NumReq-1:0]       grant,
    input  logic [NumReq*NumIO-1:0] req_dir,
    input  logic [NumReq*NumIO-1:0] req_out,
    input  logic [NumIO-1:0]        reg_dir,
    input  logic [NumIO-1:0]        reg_out,
    output logic [NumIO-1:0]        pin_dir,
    output logic [NumIO-1:0]        pin_out,
    output logic                    busy,
    output logic [IdW-1:0]          owner_id,
    output logic                    timeout_evt
);

    // Timer only has to reach TimeoutCycles-1; it saturates so it cannot wrap
    // when the timeout is disabled.
    localparam int unsigned     TimerW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimerLast = (TimeoutCycles > 0) ? TimerW'(TimeoutCycles - 1) : '0;
    localparam logic [TimerW-1:0] TimerMax  = '1;

    gpio_arb_state_e   state_q, state_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [IdW-1:0]    owner_id_q, owner_id_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              timeout_evt_q, timeout_evt_d;

    logic              pick_valid;
    logic [IdW-1:0]    pick_idx;
    logic              owner_rel, owner_drop, timed_out;

    rr_arbiter #(.NumReq(NumReq)) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        grant_d       = grant_q;
        owner_id_d    = owner_id_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        timeout_evt_d = 1'b0;

        owner_rel  = rel[owner_id_q];
        owner_drop = !req[owner_id_q];
        timed_out  = (TimeoutCycles != 0) && (timer_q == TimerLast);

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = OWNED;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_id_d        = pick_idx;
                    timer_d           = '0;
                    rr_ptr_d          = (pick_idx == IdW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            OWNED: begin
                if (owner_rel || owner_drop || timed_out) begin
                    state_d       = HANDOVER;
                    grant_d       = '0;
                    // A release or request drop in the same cycle wins over
                    // the timeout: that is a normal hand-back.
                    timeout_evt_d = timed_out && !owner_rel && !owner_drop;
                end else if (timer_q != TimerMax) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HANDOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_id_q    <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_id_q    <= owner_id_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    // Pin mux from registered state: no added latency after grant.
    always_comb begin
        pin_dir = reg_dir;
        pin_out = reg_out;
        unique case (state_q)
            OWNED: begin
                pin_dir = req_dir[int'(owner_id_q) * NumIO +: NumIO];
                pin_out = req_out[int'(owner_id_q) * NumIO +: NumIO];
            end
            HANDOVER: begin
                // Turnaround: all pins tristate between successive owners.
                pin_dir = '0;
                pin_out = '0;
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign owner_id    = owner_id_q;
    assign busy        = (state_q != IDLE);
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gpio_pin_arbiter
// Directed scenarios plus randomized traffic against a behavioural model of
// the ownership rules (who owns the bank, how long, and what the pins show).
// ----------------------------------------------------------------------------
module tb_gpio_pin_arbiter;

    localparam int NIO = 32;
    localparam int NR  = 4;
    localparam int TC  = 8;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req, rel, grant;
    logic [NR*NIO-1:0] req_dir, req_out;
    logic [NIO-1:0]    reg_dir, reg_out, pin_dir, pin_out;
    logic              busy;
    logic [1:0]        owner_id;
    logic              timeout_evt;

    int n_pass  = 0;
    int n_total = 0;

    gpio_pin_arbiter #(.NumIO(NIO), .NumReq(NR), .TimeoutCycles(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .req_dir     (req_dir),
        .req_out     (req_out),
        .reg_dir     (reg_dir),
        .reg_out     (reg_out),
        .pin_dir     (pin_dir),
        .pin_out     (pin_out),
        .busy        (busy),
        .owner_id    (owner_id),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_owner: requester owning the bank (-1 = nobody); m_ho: turnaround cycle;
    // m_age: cycles owned so far minus one; m_ptr: requester with top priority.
    int m_owner = -1;
    int m_last  = 0;
    int m_age   = 0;
    int m_ptr   = 0;
    bit m_ho    = 0;
    bit m_tevt  = 0;

    task automatic model_step();
        bit released, expired;
        if (rst) begin
            m_owner = -1; m_last = 0; m_age = 0; m_ptr = 0; m_ho = 0; m_tevt = 0;
        end else if (m_ho) begin
            m_ho = 0; m_tevt = 0;
        end else if (m_owner >= 0) begin
            released = rel[m_owner] || !req[m_owner];
            expired  = (m_age == TC - 1);
            if (released || expired) begin
                m_tevt  = expired && !released;
                m_ho    = 1;
                m_owner = -1;
            end else begin
                m_age++;
                m_tevt = 0;
            end
        end else begin
            m_tevt = 0;
            for (int k = 0; k < NR; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NR]) begin
                    m_owner = (m_ptr + k) % NR;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_age  = 0;
                m_ptr  = (m_owner + 1) % NR;
            end
        end
    endtask

    function automatic logic [71:0] exp_vec();
        logic [3:0]  g;
        logic [31:0] d, o;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        if (m_owner >= 0) begin
            d = req_dir[m_owner*NIO +: NIO];
            o = req_out[m_owner*NIO +: NIO];
        end else if (m_ho) begin
            d = '0;
            o = '0;
        end else begin
            d = reg_dir;
            o = reg_out;
        end
        return {g, 2'(m_last), (m_owner >= 0) || m_ho, m_tevt, d, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 12) begin
            tick();
            k++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b, required 0 within 12 cycles", busy);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [71:0] got, want;
        rst = 1'b1; req = '0; rel = '0;
        req_dir = '0; req_out = '0;
        reg_dir = 32'h0000FFFF; reg_out = 32'h000000A5;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_total++;
        if (pin_dir !== 32'h0000FFFF || pin_out !== 32'h000000A5)
            $display("FAIL reset_pins: dir=%h out=%h, required 0000ffff/000000a5", pin_dir, pin_out);
        else n_pass++;
        n_total++;
        if (grant !== 4'b0 || busy !== 1'b0 || owner_id !== 2'd0 || timeout_evt !== 1'b0)
            $display("FAIL reset_state: grant=%b busy=%b id=%0d tevt=%b, required 0", grant, busy, owner_id, timeout_evt);
        else n_pass++;
        got = {grant, owner_id, busy, timeout_evt, pin_dir, pin_out}; want = exp_vec();
        n_total++;
        if (got !== want) $display("FAIL reset_model: got %h want %h", got, want);
        else n_pass++;
    endtask

    task automatic test_single_grant();
        logic [71:0] got, want;
        for (int r = 0; r < NR; r++) begin
            req_dir[r*NIO +: NIO] = 32'h1111_0000 * (r + 1);
            req_out[r*NIO +: NIO] = 32'h0000_2222 * (r + 1);
        end
        req = 4'b0100;
        tick();
        n_total++;
        if (grant !== 4'b0100 || owner_id !== 2'd2 || busy !== 1'b1)
            $display("FAIL single_grant: grant=%b id=%0d busy=%b, required 0100/2/1", grant, owner_id, busy);
        else n_pass++;
        n_total++;
        if (pin_dir !== 32'h3333_0000 || pin_out !== 32'h0000_6666)
            $display("FAIL single_pins: dir=%h out=%h, required 33330000/00006666", pin_dir, pin_out);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {grant, owner_id, busy, timeout_evt, pin_dir, pin_out}; want = exp_vec();
            n_total++;
            if (got !== want) $display("FAIL single_hold: got %h want %h", got, want);
            else n_pass++;
        end
        rel = 4'b0100;
        tick();
        rel = '0;
        n_total++;
        if (pin_dir !== 32'h0 || pin_out !== 32'h0 || grant !== 4'b0 || busy !== 1'b1)
            $display("FAIL single_handover: dir=%h out=%h grant=%b busy=%b, required 0/0/0/1", pin_dir, pin_out, grant, busy);
        else n_pass++;
        req = '0;
        tick();
        n_total++;
        if (busy !== 1'b0 || pin_dir !== reg_dir)
            $display("FAIL single_idle: busy=%b dir=%h, required 0/%h", busy, pin_dir, reg_dir);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int seen, k;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            k = 0;
            while (grant === 4'b0 && k < 10) begin tick(); k++; end
            seen = -1;
            for (int b = 0; b < NR; b++) if (grant[b]) seen = b;
            n_total++;
            if (seen != order[n]) $display("FAIL rr_order[%0d]: owner=%0d, required %0d", n, seen, order[n]);
            else n_pass++;
            tick(); tick();
            rel = 4'(grant);
            tick();
            rel = '0;
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_timeout();
        int cnt = 0, k = 0;
        req = 4'b0010;
        while (grant !== 4'b0010 && k < 10) begin tick(); k++; end
        while (grant === 4'b0010 && cnt < 20) begin tick(); cnt++; end
        n_total++;
        if (cnt != TC) $display("FAIL timeout_len: owned %0d cycles, required %0d", cnt, TC);
        else n_pass++;
        n_total++;
        if (timeout_evt !== 1'b1 || busy !== 1'b1)
            $display("FAIL timeout_evt: tevt=%b busy=%b, required 1/1", timeout_evt, busy);
        else n_pass++;
        tick();
        n_total++;
        if (timeout_evt !== 1'b0) $display("FAIL timeout_pulse: tevt=%b, required 0", timeout_evt);
        else n_pass++;
        tick();
        n_total++;
        if (grant !== 4'b0010) $display("FAIL timeout_requeue: grant=%b, required 0010", grant);
        else n_pass++;
        req = '0;
        wait_idle();
    endtask

    task automatic test_timeout_with_rel();
        int k = 0;
        req = 4'b0010;
        while (grant !== 4'b0010 && k < 10) begin tick(); k++; end
        for (int c = 0; c < TC - 1; c++) tick();
        n_total++;
        if (grant !== 4'b0010) $display("FAIL trel_held: grant=%b, required 0010", grant);
        else n_pass++;
        rel = 4'b0010;
        tick();
        rel = '0;
        n_total++;
        if (grant !== 4'b0 || busy !== 1'b1 || timeout_evt !== 1'b0)
            $display("FAIL trel_release: grant=%b busy=%b tevt=%b, required 0/1/0", grant, busy, timeout_evt);
        else n_pass++;
        req = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid_ownership();
        int k = 0;
        req = 4'b1111;
        while (grant === 4'b0 && k < 10) begin tick(); k++; end
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (grant !== 4'b0 || owner_id !== 2'd0 || busy !== 1'b0 || pin_dir !== reg_dir || pin_out !== reg_out)
            $display("FAIL rst_mid: grant=%b id=%0d busy=%b dir=%h out=%h, required 0/0/0/%h/%h",
                     grant, owner_id, busy, pin_dir, pin_out, reg_dir, reg_out);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (grant !== 4'b0001 || owner_id !== 2'd0)
            $display("FAIL rst_regrant: grant=%b id=%0d, required 0001/0", grant, owner_id);
        else n_pass++;
        req = '0;
        wait_idle();
    endtask

    task automatic test_random();
        logic [71:0] got, want;
        int errs = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            rel = 4'($urandom & $urandom & $urandom);
            reg_dir = $urandom; reg_out = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                req_dir = {$urandom, $urandom, $urandom, $urandom};
                req_out = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            got = {grant, owner_id, busy, timeout_evt, pin_dir, pin_out}; want = exp_vec();
            n_total++;
            if (got !== want) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got %h want %h", c, got, want);
                errs++;
            end else n_pass++;
            n_total++;
            if ((grant & (grant - 4'd1)) !== 4'b0) $display("FAIL onehot[%0d]: grant=%b", c, grant);
            else n_pass++;
        end
        rst = 1'b0; req = '0; rel = '0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_timeout();
        test_timeout_with_rel();
        test_reset_mid_ownership();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_pin_arbiter.md
Name: gpio_pin_arbiter

Overview:
- Shares one GPIO pin bank between the software-programmed GPIO register bank and NumReq hardware requesters (bit-bang engines, debug probes).
- At most one requester owns the bank at a time; the owner's direction/output vectors drive the pins.
- When no requester owns the bank, the register-bank dir/out values pass through unchanged.
- Grants are round-robin. Every ownership hand-back inserts a tristate turnaround cycle. Ownership is bounded by a timeout.

Parameters:
- NumIO, 32, number of GPIO pins in the bank
- NumReq, 4, number of hardware requesters (>=2)
- TimeoutCycles, 1024, maximum ownership length in cycles; 0 disables the timeout

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  NumReq  per-requester request level; held high while ownership is wanted
- rel  input  NumReq  per-requester one-cycle release pulse
- grant  output  NumReq  one-hot ownership indication, registered
- req_dir  input  NumReq*NumIO  requester direction vectors; requester r occupies bits [r*NumIO +: NumIO]; 1 = output
- req_out  input  NumReq*NumIO  requester output vectors, same packing as req_dir
- reg_dir  input  NumIO  direction vector from the GPIO register bank
- reg_out  input  NumIO  output vector from the GPIO register bank
- pin_dir  output  NumIO  direction vector to the pin drivers
- pin_out  output  NumIO  output vector to the pin drivers
- busy  output  1  high in OWNED and HANDOVER
- owner_id  output  max(1,$clog2(NumReq))  index of the current or last owner
- timeout_evt  output  1  one-cycle pulse when a timeout forces a release

Behaviour:
- Reset values (rst high at a clock edge; overrides all other inputs, including mid-ownership):
  - state=IDLE, grant=0, owner_id=0, rr_ptr=0, timer=0, timeout_evt=0, busy=0.
  - pin_dir/pin_out then follow reg_dir/reg_out.
- States: IDLE, OWNED, HANDOVER.
- IDLE:
  - Pin mux selects reg_dir/reg_out.
  - If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - At the next edge: state=OWNED, grant[w]=1, owner_id=w, timer=0, rr_ptr=(w+1) mod NumReq.
  - Latency: req sampled at edge t gives grant and pin drive at t+1.
- OWNED:
  - pin_dir=req_dir[owner], pin_out=req_out[owner]. Combinational mux from the registered owner_id; no extra latency.
  - timer increments every cycle.
  - Leave to HANDOVER at the next edge when any of these holds:
    - rel[owner] is high;
    - req[owner] is low;
    - TimeoutCycles!=0 and timer==TimeoutCycles-1.
  - On the exit edge grant clears.
  - timeout_evt pulses for one cycle, registered alongside the HANDOVER entry, only if the timeout was the sole cause. rel or req-drop on the same cycle as the timeout counts as a normal release.
  - rel or req activity from non-owners is ignored; their requests stay pending.
- HANDOVER:
  - Exactly one cycle with pin_dir=0 (all tristate) and pin_out=0. This prevents contention between successive owners.
  - Then IDLE, unconditionally. The earliest re-grant is therefore 2 cycles after release.
- Fairness:
  - rr_ptr advances past the last owner, so a continuously requesting requester cannot be granted twice in a row while another requests.
  - A timed-out requester that still holds req is re-queued normally.
- Boundary conditions:
  - Timer is wide enough to hold TimeoutCycles-1 and never wraps.
  - TimeoutCycles=1 means at most one owned cycle.
  - rr_ptr wraps from NumReq-1 to 0.
- grant is one-hot or zero at all times.
- busy = (state != IDLE).

Decomposition:
- Shared package gpio_pkg:
  - state enum gpio_arb_state_e {IDLE, OWNED, HANDOVER};
  - helper function rr_pick(req, ptr) returning {found, index}.
- Sub-module rr_arbiter:
  - combinational round-robin priority picker;
  - parameter NumReq; inputs req, ptr; outputs valid, idx.
  - Reusable by the bus interconnect.
- gpio_pin_arbiter holds the FSM, timer, pointer and pin mux.

Test Plan:
- Reset then idle, reg_dir=0x0000FFFF, reg_out=0x000000A5 -> pin_dir=0x0000FFFF, pin_out=0x000000A5; grant=0; busy=0.
- req=0b0100 at edge t -> grant=0b0100 and owner_id=2 at t+1, pins follow req_dir[2]/req_out[2]. rel[2] pulse at t+5 -> pin_dir=0 at t+6 (HANDOVER), IDLE at t+7.
- req=0b1111 held continuously, each owner pulses rel after 3 cycles -> grant order 0,1,2,3,0; no requester granted twice in a row.
- TimeoutCycles=8, req[1] held, no rel -> grant[1] high for exactly 8 cycles, then timeout_evt one pulse; next grant goes to another pending requester if any, else back to 1.
- rel[owner] on the same cycle the timer reaches TimeoutCycles-1 -> HANDOVER entered, timeout_evt stays 0.
- rst asserted while OWNED with req still high -> next edge grant=0, owner_id=0, pins=reg_dir/reg_out; re-grant one cycle after rst deasserts, starting search at index 0.
